// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine change path: coin encodings, coin values and
// dispenser FSM states.
package vm_pkg;

   localparam int unsigned NumCoins = 5;

   typedef enum logic [2:0] {
      CoinNickel  = 3'd0,
      CoinDime    = 3'd1,
      CoinQuarter = 3'd2,
      CoinFifty   = 3'd3,
      CoinDollar  = 3'd4
   } coin_e;

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StIssue,
      StDone,
      StShort
   } state_e;

   // Face value in cents of a coin select.
   function automatic logic [8:0] coin_value(coin_e c);
      case (c)
         CoinNickel:  return 9'd5;
         CoinDime:    return 9'd10;
         CoinQuarter: return 9'd25;
         CoinFifty:   return 9'd50;
         CoinDollar:  return 9'd100;
         default:     return 9'd0;
      endcase
   endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request / hopper / status bundle of the change dispenser. The slave modport is the
// dispenser side, the master modport is the payment-logic and hopper side.
interface change_dispenser_if;

   logic       change_valid;
   logic [8:0] change_cents;
   logic       change_ready;
   logic       restock;
   logic       coin_req;
   logic [2:0] coin_sel;
   logic       coin_ack;
   logic       done;
   logic       short_change;
   logic [8:0] remaining;
   logic [6:0] tally_nickel;
   logic [6:0] tally_dime;
   logic [6:0] tally_quarter;
   logic [6:0] tally_fifty;
   logic [6:0] tally_dollar;
   logic [4:0] stock_empty;

   modport slave (
      input  change_valid, change_cents, restock, coin_ack,
      output change_ready, coin_req, coin_sel, done, short_change, remaining,
             tally_nickel, tally_dime, tally_quarter, tally_fifty, tally_dollar, stock_empty
   );

   modport master (
      output change_valid, change_cents, restock, coin_ack,
      input  change_ready, coin_req, coin_sel, done, short_change, remaining,
             tally_nickel, tally_dime, tally_quarter, tally_fifty, tally_dollar, stock_empty
   );

endinterface

// File: rtl/coin_picker.sv
// Greedy coin choice: largest coin whose value fits in the remaining amount and whose tube
// is not empty. Fifty-cent coins are candidates only when DISPENSE_FIFTY_EN is defined.
module coin_picker
   import vm_pkg::*;
(
   input  logic [8:0]          remaining_i,
   input  logic [NumCoins-1:0] stock_empty_i,
   output coin_e               sel_o,
   output logic                found_o
);

   // Priority chain from the largest denomination down.
   always_comb begin
      sel_o   = CoinNickel;
      found_o = 1'b0;
      if (!stock_empty_i[CoinDollar] && remaining_i >= coin_value(CoinDollar)) begin
         sel_o   = CoinDollar;
         found_o = 1'b1;
      end
`ifdef DISPENSE_FIFTY_EN
      else if (!stock_empty_i[CoinFifty] && remaining_i >= coin_value(CoinFifty)) begin
         sel_o   = CoinFifty;
         found_o = 1'b1;
      end
`endif
      else if (!stock_empty_i[CoinQuarter] && remaining_i >= coin_value(CoinQuarter)) begin
         sel_o   = CoinQuarter;
         found_o = 1'b1;
      end else if (!stock_empty_i[CoinDime] && remaining_i >= coin_value(CoinDime)) begin
         sel_o   = CoinDime;
         found_o = 1'b1;
      end else if (!stock_empty_i[CoinNickel] && remaining_i >= coin_value(CoinNickel)) begin
         sel_o   = CoinNickel;
         found_o = 1'b1;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a change amount coin by coin, greedy largest-first, tracking tube
// stock and per-request tallies. Optional feature macro: DISPENSE_FIFTY_EN (fifty-cent tube).
module change_dispenser
   import vm_pkg::*;
#(
   parameter int unsigned STOCK_W      = 8,
   parameter int unsigned INIT_NICKEL  = 20,
   parameter int unsigned INIT_DIME    = 20,
   parameter int unsigned INIT_QUARTER = 20,
   parameter int unsigned INIT_FIFTY   = 10,
   parameter int unsigned INIT_DOLLAR  = 10
) (
   input  logic                clk,
   input  logic                cancelReset,
   change_dispenser_if.slave   bus
);

   typedef logic [STOCK_W-1:0] stock_t;

   state_e     state_q, state_d;
   logic [8:0] rem_q, rem_d;
   coin_e      sel_q, sel_d;
   stock_t     nickel_q, nickel_d, dime_q, dime_d, quarter_q, quarter_d, dollar_q, dollar_d;
   logic [6:0] t_nickel_q, t_nickel_d, t_dime_q, t_dime_d, t_quarter_q, t_quarter_d;
   logic [6:0] t_dollar_q, t_dollar_d;
`ifdef DISPENSE_FIFTY_EN
   stock_t     fifty_q, fifty_d;
   logic [6:0] t_fifty_q, t_fifty_d;
`else
   // No fifty tube in this build; the parameter is kept so both builds share one interface.
   logic       unused_init_fifty;
   assign unused_init_fifty = (INIT_FIFTY != 0);
`endif

   logic [NumCoins-1:0] stock_empty;
   coin_e               pick_sel;
   logic                pick_found;

   // Tube-empty flags; an absent fifty tube always reads empty.
   always_comb begin
      stock_empty              = '1;
      stock_empty[CoinNickel]  = (nickel_q == '0);
      stock_empty[CoinDime]    = (dime_q == '0);
      stock_empty[CoinQuarter] = (quarter_q == '0);
      stock_empty[CoinDollar]  = (dollar_q == '0);
`ifdef DISPENSE_FIFTY_EN
      stock_empty[CoinFifty]   = (fifty_q == '0);
`endif
   end

   coin_picker u_picker (
      .remaining_i   (rem_q),
      .stock_empty_i (stock_empty),
      .sel_o         (pick_sel),
      .found_o       (pick_found)
   );

   // Next-state, remaining amount, stock and tally updates.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      sel_d       = sel_q;
      nickel_d    = nickel_q;
      dime_d      = dime_q;
      quarter_d   = quarter_q;
      dollar_d    = dollar_q;
      t_nickel_d  = t_nickel_q;
      t_dime_d    = t_dime_q;
      t_quarter_d = t_quarter_q;
      t_dollar_d  = t_dollar_q;
`ifdef DISPENSE_FIFTY_EN
      fifty_d     = fifty_q;
      t_fifty_d   = t_fifty_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.restock) begin
               nickel_d  = stock_t'(INIT_NICKEL);
               dime_d    = stock_t'(INIT_DIME);
               quarter_d = stock_t'(INIT_QUARTER);
               dollar_d  = stock_t'(INIT_DOLLAR);
`ifdef DISPENSE_FIFTY_EN
               fifty_d   = stock_t'(INIT_FIFTY);
`endif
            end
            if (bus.change_valid) begin
               rem_d       = bus.change_cents;
               t_nickel_d  = '0;
               t_dime_d    = '0;
               t_quarter_d = '0;
               t_dollar_d  = '0;
`ifdef DISPENSE_FIFTY_EN
               t_fifty_d   = '0;
`endif
               state_d     = StSelect;
            end
         end
         StSelect: begin
            if (rem_q == '0) begin
               state_d = StDone;
            end else if (pick_found) begin
               sel_d   = pick_sel;
               state_d = StIssue;
            end else begin
               state_d = StShort;
            end
         end
         StIssue: begin
            if (bus.coin_ack) begin
               // The picker only selects coins that fit, so this cannot underflow.
               rem_d   = rem_q - coin_value(sel_q);
               state_d = StSelect;
               unique case (sel_q)
                  CoinNickel: begin
                     if (nickel_q != '0) nickel_d = nickel_q - stock_t'(1);
                     t_nickel_d = t_nickel_q + 7'd1;
                  end
                  CoinDime: begin
                     if (dime_q != '0) dime_d = dime_q - stock_t'(1);
                     t_dime_d = t_dime_q + 7'd1;
                  end
                  CoinQuarter: begin
                     if (quarter_q != '0) quarter_d = quarter_q - stock_t'(1);
                     t_quarter_d = t_quarter_q + 7'd1;
                  end
`ifdef DISPENSE_FIFTY_EN
                  CoinFifty: begin
                     if (fifty_q != '0) fifty_d = fifty_q - stock_t'(1);
                     t_fifty_d = t_fifty_q + 7'd1;
                  end
`endif
                  CoinDollar: begin
                     if (dollar_q != '0) dollar_d = dollar_q - stock_t'(1);
                     t_dollar_d = t_dollar_q + 7'd1;
                  end
                  default: ;
               endcase
            end
         end
         StDone:  state_d = StIdle;
         StShort: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset abandons any request and reloads the tubes.
   always_ff @(posedge clk or posedge cancelReset) begin
      if (cancelReset) begin
         state_q     <= StIdle;
         rem_q       <= '0;
         sel_q       <= CoinNickel;
         nickel_q    <= stock_t'(INIT_NICKEL);
         dime_q      <= stock_t'(INIT_DIME);
         quarter_q   <= stock_t'(INIT_QUARTER);
         dollar_q    <= stock_t'(INIT_DOLLAR);
         t_nickel_q  <= '0;
         t_dime_q    <= '0;
         t_quarter_q <= '0;
         t_dollar_q  <= '0;
`ifdef DISPENSE_FIFTY_EN
         fifty_q     <= stock_t'(INIT_FIFTY);
         t_fifty_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         sel_q       <= sel_d;
         nickel_q    <= nickel_d;
         dime_q      <= dime_d;
         quarter_q   <= quarter_d;
         dollar_q    <= dollar_d;
         t_nickel_q  <= t_nickel_d;
         t_dime_q    <= t_dime_d;
         t_quarter_q <= t_quarter_d;
         t_dollar_q  <= t_dollar_d;
`ifdef DISPENSE_FIFTY_EN
         fifty_q     <= fifty_d;
         t_fifty_q   <= t_fifty_d;
`endif
      end
   end

   assign bus.change_ready  = (state_q == StIdle);
   assign bus.coin_req      = (state_q == StIssue);
   assign bus.coin_sel      = sel_q;
   assign bus.done          = (state_q == StDone);
   assign bus.short_change  = (state_q == StShort);
   assign bus.remaining     = rem_q;
   assign bus.tally_nickel  = t_nickel_q;
   assign bus.tally_dime    = t_dime_q;
   assign bus.tally_quarter = t_quarter_q;
   assign bus.tally_dollar  = t_dollar_q;
   assign bus.stock_empty   = stock_empty;
`ifdef DISPENSE_FIFTY_EN
   assign bus.tally_fifty   = t_fifty_q;
`else
   assign bus.tally_fifty   = 7'd0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: directed requests push expected coins and end
// events; a monitor pops and compares on every hopper handshake and done/short pulse.
module tb_change_dispenser;
   import vm_pkg::*;

   logic clk = 1'b0;
   logic cancelReset;
   always #5 clk = ~clk;

   change_dispenser_if bus ();

   change_dispenser dut (
      .clk         (clk),
      .cancelReset (cancelReset),
      .bus         (bus)
   );

`ifdef DISPENSE_FIFTY_EN
   localparam logic [4:0] EmptyReset = 5'b00000;
`else
   localparam logic [4:0] EmptyReset = 5'b01000;
`endif

   localparam int KCoin = 0, KDone = 1, KShort = 2;

   typedef struct {
      int kind;
      int sel;
      int rem;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   ends_seen = 0;
   int   short_seen = 0;
   logic hold_ack = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push_coin(input int sel);
      exp_t e;
      e.kind = KCoin; e.sel = sel; e.rem = 0;
      exp_q.push_back(e);
   endtask

   task automatic push_end(input int kind, input int rem);
      exp_t e;
      e.kind = kind; e.sel = 0; e.rem = rem;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input int kind, input int val);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard: unexpected event kind %0d value %0d, expected none", kind, val);
      end else begin
         e = exp_q.pop_front();
         check("event kind", kind, e.kind);
         if (e.kind == KCoin) check("coin_sel", val, e.sel);
         else                 check("remaining at end", val, e.rem);
      end
   endtask

   // Hopper model: acknowledges a pending coin one cycle in unless held off.
   initial begin
      bus.coin_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.coin_ack = bus.coin_req && !hold_ack;
      end
   end

   // Monitor: every ejected coin and every end pulse is matched against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!cancelReset) begin
            if (bus.coin_req && bus.coin_ack) pop_cmp(KCoin, int'(bus.coin_sel));
            if (bus.done) begin
               pop_cmp(KDone, int'(bus.remaining));
               ends_seen++;
            end
            if (bus.short_change) begin
               pop_cmp(KShort, int'(bus.remaining));
               ends_seen++;
               short_seen++;
            end
         end
      end
   end

   task automatic request(input logic [8:0] cents, output int start);
      int c;
      c = 0;
      @(negedge clk);
      while (!bus.change_ready && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("change_ready before request", bus.change_ready, 1);
      start = ends_seen;
      bus.change_valid = 1'b1;
      bus.change_cents = cents;
      @(posedge clk);
      #1;
      bus.change_valid = 1'b0;
   endtask

   task automatic wait_end(input int start);
      int c;
      c = 0;
      while (ends_seen <= start && c < 400) begin
         @(negedge clk);
         c++;
      end
      if (ends_seen <= start) begin
         n_checks++;
         n_errors++;
         $display("FAIL end timeout: got no done/short after %0d cycles, expected one", c);
      end
   endtask

   task automatic pay_500();
      int s;
      for (int i = 0; i < 5; i++) push_coin(CoinDollar);
      push_end(KDone, 0);
      request(9'd500, s);
      wait_end(s);
   endtask

   initial begin
      int  s;
      int  s0;
      logic stable;

      cancelReset      = 1'b1;
      bus.change_valid = 1'b0;
      bus.change_cents = '0;
      bus.restock      = 1'b0;
      repeat (2) @(negedge clk);
      cancelReset = 1'b0;
      @(negedge clk);

      // Reset state.
      check("reset change_ready", bus.change_ready, 1);
      check("reset coin_req", bus.coin_req, 0);
      check("reset coin_sel", bus.coin_sel, 0);
      check("reset done", bus.done, 0);
      check("reset remaining", bus.remaining, 0);
      check("reset tally_quarter", bus.tally_quarter, 0);
      check("reset stock_empty", bus.stock_empty, EmptyReset);

      // 90 cents with full tubes, plus accept-to-coin latency.
`ifdef DISPENSE_FIFTY_EN
      push_coin(CoinFifty); push_coin(CoinQuarter); push_coin(CoinDime); push_coin(CoinNickel);
`else
      push_coin(CoinQuarter); push_coin(CoinQuarter); push_coin(CoinQuarter);
      push_coin(CoinDime); push_coin(CoinNickel);
`endif
      push_end(KDone, 0);
      request(9'd90, s);
      @(negedge clk);
      check("coin_req one cycle after accept", bus.coin_req, 0);
      @(negedge clk);
      check("coin_req two cycles after accept", bus.coin_req, 1);
      wait_end(s);
`ifdef DISPENSE_FIFTY_EN
      check("90 tally_fifty", bus.tally_fifty, 1);
      check("90 tally_quarter", bus.tally_quarter, 1);
`else
      check("90 tally_fifty", bus.tally_fifty, 0);
      check("90 tally_quarter", bus.tally_quarter, 3);
`endif
      check("90 tally_dime", bus.tally_dime, 1);
      check("90 tally_nickel", bus.tally_nickel, 1);

      // Zero amount: done two cycles after accept, no coin.
      push_end(KDone, 0);
      request(9'd0, s);
      @(negedge clk);
      check("zero done early", bus.done, 0);
      check("zero coin_req", bus.coin_req, 0);
      @(negedge clk);
      check("zero done at 2 cycles", bus.done, 1);
      check("zero tallies cleared", bus.tally_nickel, 0);

      // Below the smallest coin.
      push_end(KShort, 3);
      request(9'd3, s);
      wait_end(s);
      repeat (2) @(negedge clk);
      check("short remaining held", bus.remaining, 3);

      // Drain the dollar tube, then 100 cents must avoid dollars.
      pay_500();
      pay_500();
      check("dollar tube empty", bus.stock_empty[4], 1);
`ifdef DISPENSE_FIFTY_EN
      push_coin(CoinFifty); push_coin(CoinFifty);
`else
      for (int i = 0; i < 4; i++) push_coin(CoinQuarter);
`endif
      push_end(KDone, 0);
      request(9'd100, s);
      wait_end(s);
      check("100 tally_dollar", bus.tally_dollar, 0);
`ifdef DISPENSE_FIFTY_EN
      check("100 tally_fifty", bus.tally_fifty, 2);
`else
      check("100 tally_quarter", bus.tally_quarter, 4);
`endif

      // Drain the 19 remaining nickels, then 15 cents falls short by 5.
      for (int i = 0; i < 19; i++) begin
         push_coin(CoinNickel);
         push_end(KDone, 0);
         request(9'd5, s);
         wait_end(s);
      end
      check("nickel tube empty", bus.stock_empty[0], 1);
      push_coin(CoinDime);
      push_end(KShort, 5);
      s0 = short_seen;
      request(9'd15, s);
      wait_end(s);
      repeat (3) @(negedge clk);
      check("short pulse count", short_seen - s0, 1);
      check("15 remaining", bus.remaining, 5);
      check("15 tally_dime", bus.tally_dime, 1);

      // Ack held off 20 cycles; restock during ISSUE must be ignored.
      hold_ack = 1'b1;
      push_coin(CoinQuarter);
      push_end(KDone, 0);
      request(9'd25, s);
      repeat (2) @(negedge clk);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (!(bus.coin_req === 1'b1 && bus.coin_sel === 3'd2)) stable = 1'b0;
         bus.restock = (i == 5);
         @(negedge clk);
      end
      bus.restock = 1'b0;
      check("coin_req/coin_sel stable while unacked", stable, 1);
      check("restock in ISSUE ignored", bus.stock_empty[0], 1);
      hold_ack = 1'b0;
      wait_end(s);
      check("nickel still empty after ISSUE restock", bus.stock_empty[0], 1);

      // Reset in the middle of ISSUE.
      hold_ack = 1'b1;
      request(9'd10, s);
      repeat (2) @(negedge clk);
      check("pre-reset coin_req", bus.coin_req, 1);
      check("pre-reset coin_sel", bus.coin_sel, 1);
      #1;
      cancelReset = 1'b1;
      #1;
      check("reset drops coin_req at once", bus.coin_req, 0);
      check("reset reloads stock", bus.stock_empty, EmptyReset);
      check("reset clears remaining", bus.remaining, 0);
      hold_ack = 1'b0;
      @(negedge clk);
      cancelReset = 1'b0;
      @(negedge clk);
      check("change_ready after reset", bus.change_ready, 1);

      // Restock in IDLE after depletion.
      pay_500();
      pay_500();
      check("dollar empty before restock", bus.stock_empty[4], 1);
      @(negedge clk);
      bus.restock = 1'b1;
      @(posedge clk);
      #1;
      bus.restock = 1'b0;
      @(negedge clk);
      check("restock in IDLE", bus.stock_empty, EmptyReset);

      check("scoreboard drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
